// File: rtl/enemy_attack_ctrl.sv
// Enemy attack initiator: range-gated windup/strike/cooldown FSM stepped on game-frame ticks,
// with a strike strobe to gamelogic, enemy facing for sprites and a saturating strike counter.
module enemy_attack_ctrl #(
  parameter logic [8:0] RANGE           = 9'd20,
  parameter logic [7:0] WINDUP_FRAMES   = 8'd15,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd45
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       game_frame_clk_rising_edge,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic [8:0] Enemy_X,
  input  logic [8:0] Enemy_Y,
  input  logic       Enemy_Alive,
  output logic       Enemy_Attack_On,
  output logic [1:0] Enemy_State,
  output logic [1:0] Enemy_Direction,
  output logic [7:0] Attack_Count
);

  localparam int unsigned POS_W = 9;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WINDUP   = 2'd1,
    STRIKE   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         dir_q, dir_d;
  logic [POS_W-1:0]   dx, dy;
  logic               in_range;
  logic [1:0]         facing;
  logic               tick;

  assign tick = game_frame_clk_rising_edge;

  // Unsigned magnitudes: subtract the smaller coordinate so nothing wraps.
  assign dx = (Player_X >= Enemy_X) ? POS_W'(Player_X - Enemy_X) : POS_W'(Enemy_X - Player_X);
  assign dy = (Player_Y >= Enemy_Y) ? POS_W'(Player_Y - Enemy_Y) : POS_W'(Enemy_Y - Player_Y);
  assign in_range = (dx <= RANGE) && (dy <= RANGE);

  // Dominant axis picks facing; ties (including equal positions) resolve horizontally.
  always_comb begin
    facing = 2'd3;
    if (dx >= dy) begin
      facing = (Player_X < Enemy_X) ? 2'd1 : 2'd3;
    end else begin
      facing = (Player_Y > Enemy_Y) ? 2'd0 : 2'd2;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      dir_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // Next state; a dead enemy overrides every transition, tick or not.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    dir_d   = dir_q;
    if (!Enemy_Alive) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (tick) begin
      dir_d = facing;
      case (state_q)
        IDLE: begin
          if (in_range) begin
            state_d = WINDUP;
            cnt_d   = '0;
          end
        end
        WINDUP: begin
          if (!in_range) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(WINDUP_FRAMES - 8'd1)) begin
            state_d = STRIKE;
            cnt_d   = '0;
            if (count_q != 8'd255) begin
              count_d = CNT_W'(count_q + 8'd1);
            end
          end else begin
            cnt_d = CNT_W'(cnt_q + 8'd1);
          end
        end
        STRIKE: begin
          state_d = COOLDOWN;
          cnt_d   = '0;
        end
        COOLDOWN: begin
          if (cnt_q == CNT_W'(COOLDOWN_FRAMES - 8'd1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = CNT_W'(cnt_q + 8'd1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Strike strobe is gated by Alive so it drops in the same cycle the enemy dies.
  assign Enemy_Attack_On = (state_q == STRIKE) && Enemy_Alive;
  assign Enemy_State     = state_q;
  assign Enemy_Direction = dir_q;
  assign Attack_Count    = count_q;

endmodule

// File: tb/tb_enemy_attack_ctrl.sv
// Bench for enemy_attack_ctrl: a behavioural reference model queues expected outputs per clock,
// popped and compared after each edge, plus directed checks at the scenario milestones.
module tb_enemy_attack_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic       game_frame_clk_rising_edge;
  logic [8:0] Player_X, Player_Y, Enemy_X, Enemy_Y;
  logic       Enemy_Alive;
  logic       Enemy_Attack_On;
  logic [1:0] Enemy_State;
  logic [1:0] Enemy_Direction;
  logic [7:0] Attack_Count;

  enemy_attack_ctrl dut (
    .Clk                        (Clk),
    .Reset_n                    (Reset_n),
    .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
    .Player_X                   (Player_X),
    .Player_Y                   (Player_Y),
    .Enemy_X                    (Enemy_X),
    .Enemy_Y                    (Enemy_Y),
    .Enemy_Alive                (Enemy_Alive),
    .Enemy_Attack_On            (Enemy_Attack_On),
    .Enemy_State                (Enemy_State),
    .Enemy_Direction            (Enemy_Direction),
    .Attack_Count               (Attack_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] dir;
    logic [7:0] cnt;
    logic       on;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_state = 0;
  int m_cnt   = 0;
  int m_dir   = 0;
  int m_count = 0;
  int exp_dmg = 0;
  int obs_dmg = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_dir   = 0;
    m_count = 0;
  endtask

  // One Clk cycle: predict from current inputs, push, clock, pop and compare.
  task automatic step(input logic t);
    exp_t e;
    int px, py, ex, ey, dx, dy;
    bit inr;
    game_frame_clk_rising_edge = t;
    #2;
    px = Player_X; py = Player_Y; ex = Enemy_X; ey = Enemy_Y;
    dx = (px > ex) ? px - ex : ex - px;
    dy = (py > ey) ? py - ey : ey - py;
    inr = (dx <= 20) && (dy <= 20);
    if (t && Enemy_Attack_On) obs_dmg += 10;
    if (t && Enemy_Alive && m_state == 2) exp_dmg += 10;
    if (!Enemy_Alive) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (t) begin
      if (dx >= dy) m_dir = (px < ex) ? 1 : 3;
      else          m_dir = (py > ey) ? 0 : 2;
      case (m_state)
        0: if (inr) begin m_state = 1; m_cnt = 0; end
        1: begin
          if (!inr) begin
            m_state = 0;
            m_cnt   = 0;
          end else if (m_cnt == 15 - 1) begin
            m_state = 2;
            m_cnt   = 0;
            if (m_count < 255) m_count++;
          end else begin
            m_cnt++;
          end
        end
        2: begin m_state = 3; m_cnt = 0; end
        default: begin
          if (m_cnt == 45 - 1) begin m_state = 0; m_cnt = 0; end
          else m_cnt++;
        end
      endcase
    end
    e.st  = 2'(m_state);
    e.dir = 2'(m_dir);
    e.cnt = 8'(m_count);
    e.on  = (m_state == 2) && Enemy_Alive;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check("state", int'(Enemy_State), int'(e.st));
    check("dir",   int'(Enemy_Direction), int'(e.dir));
    check("count", int'(Attack_Count), int'(e.cnt));
    check("on",    int'(Enemy_Attack_On), int'(e.on));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic to_idle();
    Enemy_Alive = 1'b0;
    step(1'b0);
    Enemy_Alive = 1'b1;
  endtask

  task automatic set_pos(input int px, input int py, input int ex, input int ey);
    Player_X = 9'(px); Player_Y = 9'(py);
    Enemy_X  = 9'(ex); Enemy_Y  = 9'(ey);
  endtask

  initial begin
    Reset_n = 1'b0;
    game_frame_clk_rising_edge = 1'b0;
    Enemy_Alive = 1'b1;
    set_pos(100, 100, 110, 105);
    repeat (2) @(posedge Clk);
    #1;
    check("rst_state", int'(Enemy_State), 0);
    check("rst_on",    int'(Enemy_Attack_On), 0);
    check("rst_count", int'(Attack_Count), 0);
    check("rst_dir",   int'(Enemy_Direction), 0);
    Reset_n = 1'b1;
    model_reset();

    // Strike: WINDUP on tick 1, STRIKE after tick 16, COOLDOWN for 45 ticks.
    ticks(1);
    check("strike_windup", int'(Enemy_State), 1);
    ticks(15);
    check("strike_state", int'(Enemy_State), 2);
    check("strike_count", int'(Attack_Count), 1);
    check("strike_on",    int'(Enemy_Attack_On), 1);
    check("strike_dir",   int'(Enemy_Direction), 1);
    ticks(1);
    check("cool_state", int'(Enemy_State), 3);
    check("cool_on",    int'(Enemy_Attack_On), 0);
    ticks(44);
    check("cool_hold", int'(Enemy_State), 3);
    ticks(1);
    check("cool_done", int'(Enemy_State), 0);
    check("dmg_one", obs_dmg, 10);

    // Async reset in the middle of a strike.
    ticks(16);
    check("pre_rst_state", int'(Enemy_State), 2);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_on",    int'(Enemy_Attack_On), 0);
    check("async_state", int'(Enemy_State), 0);
    check("async_count", int'(Attack_Count), 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    model_reset();

    // Abort: player walks out on windup tick 8.
    ticks(7);
    check("abort_pre", int'(Enemy_State), 1);
    set_pos(200, 100, 110, 105);
    ticks(1);
    check("abort_idle",  int'(Enemy_State), 0);
    check("abort_count", int'(Attack_Count), 0);
    ticks(3);
    check("abort_stay", int'(Enemy_State), 0);

    // Range boundary and no-wrap magnitude.
    set_pos(100, 100, 120, 120);
    ticks(1);
    check("bnd_20", int'(Enemy_State), 1);
    to_idle();
    set_pos(100, 100, 121, 100);
    ticks(1);
    check("bnd_21", int'(Enemy_State), 0);
    set_pos(0, 100, 511, 100);
    ticks(1);
    check("bnd_wrap", int'(Enemy_State), 0);
    check("bnd_dir",  int'(Enemy_Direction), 1);

    // Death mid-strike, then respawn restarts from a fresh windup.
    set_pos(100, 100, 110, 105);
    ticks(16);
    check("death_pre", int'(Enemy_State), 2);
    Enemy_Alive = 1'b0;
    #1;
    check("death_on", int'(Enemy_Attack_On), 0);
    step(1'b0);
    check("death_idle", int'(Enemy_State), 0);
    step(1'b1);
    check("death_tick_idle", int'(Enemy_State), 0);
    Enemy_Alive = 1'b1;
    ticks(1);
    check("respawn_windup", int'(Enemy_State), 1);
    ticks(14);
    check("respawn_hold", int'(Enemy_State), 1);
    ticks(1);
    check("respawn_strike", int'(Enemy_State), 2);
    check("dmg_match", obs_dmg, exp_dmg);

    // Facing.
    to_idle();
    set_pos(90, 100, 110, 105);
    ticks(1);
    check("face_left", int'(Enemy_Direction), 1);
    set_pos(100, 115, 100, 100);
    ticks(1);
    check("face_down", int'(Enemy_Direction), 0);
    set_pos(100, 100, 100, 100);
    ticks(1);
    check("face_equal", int'(Enemy_Direction), 3);

    // Saturation: hold the player in range with a tick every Clk.
    to_idle();
    set_pos(100, 100, 110, 105);
    for (int i = 0; i < 300 * 62; i++) step(1'b1);
    check("sat_count", int'(Attack_Count), 255);
    check("sat_dmg", obs_dmg, exp_dmg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
